data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter that shares the single-port, one-cycle-registered-read data memory between two requesters: port 0 is the CPU load/store stage, port 1 the debug/loader port. Round-robin grant, req/ack handshake per port; the block alone drives the memory's address, write-data and write-enable and routes the read word back to the owning requester. It sits between the datapath's MEM stage and the data memory instance.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req0 / req1  input  1  request; held high with A/WE/WD stable until the matching ack
- we0 / we1  input  1  1 = write, 0 = read
- A0 / A1  input  AW  word address
- WD0 / WD1  input  DW  write data
- ack0 / ack1  output  1  one-cycle completion pulse
- RD0 / RD1  output  DW  read data, valid only while the matching ack is high; 0 otherwise
- mem_A  output  AW  memory address (registered)
- mem_WD  output  DW  memory write data (registered)
- mem_WE  output  1  memory write enable (registered)
- mem_RD  input  DW  memory read data, registered inside memory on the edge after mem_A is presented
- busy  output  1  high in ACCESS or RESP

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, owner (0/1), last_grant (0/1), mem_A, mem_WD, mem_WE.
- Reset: state=IDLE, owner=0, last_grant=1 (port 0 wins first tie), mem_A=0, mem_WD=0, mem_WE=0; ack0=ack1=0, RD0=RD1=0, busy=0.
- IDLE: if no req, stay. Otherwise pick winner: single requester wins; both requesting → port != last_grant. Load mem_A/mem_WD/mem_WE from winner, owner=winner, last_grant=winner, → ACCESS.
- ACCESS: memory sees mem_*; write commits / read word registers at the closing edge. At that edge mem_WE←0, → RESP.
- RESP: ack[owner]=1; RD[owner]=mem_RD if owner's op was a read, else 0. Non-owner port only is considered: if its req is high, grant it (load mem_*, owner, last_grant) → ACCESS; else → IDLE. Owner's still-high req is ignored this cycle.
- mem_WE is high in ACCESS only, so each write touches the memory on exactly one edge.
- ack and RD are combinational from state/owner/mem_RD; no other outputs depend combinationally on inputs.
- Requester dropping req before ack: protocol violation; behaviour undefined, no checking required.

## Timing
- Uncontended: req sampled in IDLE cycle N → ACCESS N+1 → ack in N+2. Latency 2 cycles, throughput 1 per 3 cycles per port.
- Contended (both held high): grants alternate 0,1,0,1…; ack every 2 cycles after the first (ACCESS/RESP ping-pong, no IDLE).
- Same port re-requesting immediately after ack while other idle: passes through IDLE, ack 3 cycles after previous ack.
- Reset during ACCESS: memory still sees mem_WE at that edge (write commits; memory has no reset); no ack issued; requester must re-request.
- Reset during RESP: ack is visible that cycle; arbiter in IDLE after the edge.
- Address/data width: passed through unmodified, no alignment or truncation.

## Structure
- Shared package data_mem_arb_pkg: state enum (IDLE/ACCESS/RESP), port-id constants PORT_CPU=0, PORT_DBG=1, default AW/DW.
- One sub-module: dm_rr_pick — combinational 2-way round-robin picker (req[1:0], last_grant → valid, winner), used in IDLE and as the single-candidate check in RESP.

## Test plan
- Reset, then req0 read A0=0x10 after memory preloaded 0x10=0xDEADBEEF → ack0 two cycles later, RD0=0xDEADBEEF, RD1=0, busy high 2 cycles.
- req1 write A1=0x20 WD1=0x12345678 → mem_WE high exactly one cycle, ack1 two cycles later; following req0 read 0x20 returns 0x12345678.
- req0 and req1 both read in same cycle from reset, held continuously → acks ordered 0,1,0,1 on cycles +2,+4,+6,+8.
- req0 write A0=0x30 WD0=0xA5A5A5A5 and req1 read A1=0x30 simultaneously → port 0 first; ack1 returns RD1=0xA5A5A5A5.
- rst asserted during ACCESS of a write 0x40=0x55 → no ack, state IDLE, mem_WE=0 after edge; read of 0x40 returns 0x55.
- Only req0 held for 4 transactions → acks 3 cycles apart, port 1 outputs stay 0.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_mem_arb_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last.
module dm_rr_pick
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = PORT_CPU;
    case (req_i)
      2'b01:   winner_o = PORT_CPU;
      2'b10:   winner_o = PORT_DBG;
      2'b11:   winner_o = ~last_grant_i;
      default: winner_o = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, registered-read data memory
// between the CPU MEM stage (port 0) and the debug/loader port (port 1).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] A0,
  input  logic [DW-1:0] WD0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] A1,
  input  logic [DW-1:0] WD1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] RD0,
  output logic [DW-1:0] RD1,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WD,
  output logic          mem_WE,
  input  logic [DW-1:0] mem_RD,
  output logic          busy
);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          op_wr_q, op_wr_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;

  logic [1:0]    pick_req;
  logic          pick_valid;
  logic          pick_winner;

  // In RESP only the non-owner is a candidate; nothing is granted in ACCESS.
  always_comb begin
    pick_req = 2'b00;
    case (state_q)
      IDLE:    pick_req = {req1, req0};
      RESP:    pick_req = (owner_q == PORT_CPU) ? {req1, 1'b0} : {1'b0, req0};
      default: pick_req = 2'b00;
    endcase
  end

  dm_rr_pick u_pick (
    .req_i        (pick_req),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  // Next-state; pick_valid can only be set in IDLE or RESP.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    mem_we_d     = 1'b0;
    mem_a_d      = mem_a_q;
    mem_wd_d     = mem_wd_q;

    case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = pick_valid ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase

    if (pick_valid) begin
      owner_d      = pick_winner;
      last_grant_d = pick_winner;
      op_wr_d      = (pick_winner == PORT_DBG) ? we1 : we0;
      mem_we_d     = (pick_winner == PORT_DBG) ? we1 : we0;
      mem_a_d      = (pick_winner == PORT_DBG) ? A1  : A0;
      mem_wd_d     = (pick_winner == PORT_DBG) ? WD1 : WD0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_CPU;
      last_grant_q <= PORT_DBG;
      op_wr_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      mem_we_q     <= mem_we_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  // Response path: the registered read word is valid during RESP.
  assign ack0   = (state_q == RESP) && (owner_q == PORT_CPU);
  assign ack1   = (state_q == RESP) && (owner_q == PORT_DBG);
  assign RD0    = (ack0 && !op_wr_q) ? mem_RD : '0;
  assign RD1    = (ack1 && !op_wr_q) ? mem_RD : '0;
  assign busy   = (state_q != IDLE);
  assign mem_A  = mem_a_q;
  assign mem_WD = mem_wd_q;
  assign mem_WE = mem_we_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural
// single-port registered-read memory.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] A0, WD0, A1, WD1;
  logic        ack0, ack1;
  logic [31:0] RD0, RD1;
  logic [31:0] mem_A, mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .we0    (we0),
    .A0     (A0),
    .WD0    (WD0),
    .req1   (req1),
    .we1    (we1),
    .A1     (A1),
    .WD1    (WD1),
    .ack0   (ack0),
    .ack1   (ack1),
    .RD0    (RD0),
    .RD1    (RD1),
    .mem_A  (mem_A),
    .mem_WD (mem_WD),
    .mem_WE (mem_WE),
    .mem_RD (mem_RD),
    .busy   (busy)
  );

  // Memory model: write and read-register on the same edge, no reset.
  logic [31:0] mem [256];
  bit          preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      mem[8'h10] <= 32'hDEADBEEF;
      preloaded  <= 1'b1;
    end else if (mem_WE) begin
      mem[mem_A[7:0]] <= mem_WD;
    end
    mem_RD <= mem[mem_A[7:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    req0 = 1'b0; we0 = 1'b0; A0 = '0; WD0 = '0;
    req1 = 1'b0; we1 = 1'b0; A1 = '0; WD1 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_ports();
    tick();
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want %b", {ack0, ack1, busy, mem_WE}, 4'b0000);
    end
    n_tests++;
    if ({RD0, RD1, mem_A, mem_WD} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_data: got RD0=%h RD1=%h A=%h WD=%h want all 0", RD0, RD1, mem_A, mem_WD);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_read();
    req0 = 1'b1; we0 = 1'b0; A0 = 32'h10;
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0010 || mem_A !== 32'h10) begin
      n_fail++;
      $display("FAIL rd_access: got flags=%b A=%h want 0010 A=10", {ack0, ack1, busy, mem_WE}, mem_A);
    end
    tick();
    n_tests++;
    if ({ack0, ack1, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL rd_resp_flags: got %b want 101", {ack0, ack1, busy});
    end
    n_tests++;
    if (RD0 !== 32'hDEADBEEF || RD1 !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_resp_data: got RD0=%h RD1=%h want deadbeef 0", RD0, RD1);
    end
    req0 = 1'b0;
    tick();
    n_tests++;
    if ({ack0, ack1, busy} !== 3'b000 || RD0 !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_after: got flags=%b RD0=%h want 000 0", {ack0, ack1, busy}, RD0);
    end
  endtask

  task automatic test_write();
    req1 = 1'b1; we1 = 1'b1; A1 = 32'h20; WD1 = 32'h12345678;
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0011 || mem_A !== 32'h20 || mem_WD !== 32'h12345678) begin
      n_fail++;
      $display("FAIL wr_access: got flags=%b A=%h WD=%h want 0011 20 12345678",
               {ack0, ack1, busy, mem_WE}, mem_A, mem_WD);
    end
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0110 || RD1 !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_resp: got flags=%b RD1=%h want 0110 0", {ack0, ack1, busy, mem_WE}, RD1);
    end
    req1 = 1'b0; we1 = 1'b0;
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_after: got %b want 0000", {ack0, ack1, busy, mem_WE});
    end
    req0 = 1'b1; we0 = 1'b0; A0 = 32'h20;
    tick();
    tick();
    n_tests++;
    if (ack0 !== 1'b1 || RD0 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL wr_readback: got ack0=%b RD0=%h want 1 12345678", ack0, RD0);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_contended();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; A0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; A1 = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      logic e0, e1;
      tick();
      e0 = (c == 2) || (c == 6);
      e1 = (c == 4) || (c == 8);
      n_tests++;
      if ({ack0, ack1, busy} !== {e0, e1, 1'b1}) begin
        n_fail++;
        $display("FAIL cont_flags_c%0d: got %b want %b", c, {ack0, ack1, busy}, {e0, e1, 1'b1});
      end
      if (e0) begin
        n_tests++;
        if (RD0 !== 32'hDEADBEEF || RD1 !== 32'h0) begin
          n_fail++;
          $display("FAIL cont_rd0_c%0d: got RD0=%h RD1=%h want deadbeef 0", c, RD0, RD1);
        end
      end
      if (e1) begin
        n_tests++;
        if (RD1 !== 32'h12345678 || RD0 !== 32'h0) begin
          n_fail++;
          $display("FAIL cont_rd1_c%0d: got RD1=%h RD0=%h want 12345678 0", c, RD1, RD0);
        end
      end
    end
    idle_ports();
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_end_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_wr_rd_collision();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b1; A0 = 32'h30; WD0 = 32'hA5A5A5A5;
    req1 = 1'b1; we1 = 1'b0; A1 = 32'h30;
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0011 || mem_WD !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL coll_p0_access: got flags=%b WD=%h want 0011 a5a5a5a5", {ack0, ack1, busy, mem_WE}, mem_WD);
    end
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b1010 || RD0 !== 32'h0) begin
      n_fail++;
      $display("FAIL coll_p0_ack: got flags=%b RD0=%h want 1010 0", {ack0, ack1, busy, mem_WE}, RD0);
    end
    req0 = 1'b0; we0 = 1'b0;
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0010) begin
      n_fail++;
      $display("FAIL coll_p1_access: got %b want 0010", {ack0, ack1, busy, mem_WE});
    end
    tick();
    n_tests++;
    if (ack1 !== 1'b1 || RD1 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL coll_p1_ack: got ack1=%b RD1=%h want 1 a5a5a5a5", ack1, RD1);
    end
    idle_ports();
    tick();
  endtask

  task automatic test_reset_in_access();
    req0 = 1'b1; we0 = 1'b1; A0 = 32'h40; WD0 = 32'h55;
    tick();
    n_tests++;
    if ({busy, mem_WE} !== 2'b11) begin
      n_fail++;
      $display("FAIL rsta_access: got %b want 11", {busy, mem_WE});
    end
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0;
    tick();
    n_tests++;
    if ({ack0, ack1, busy, mem_WE} !== 4'b0000 || mem_A !== 32'h0) begin
      n_fail++;
      $display("FAIL rsta_after: got flags=%b A=%h want 0000 0", {ack0, ack1, busy, mem_WE}, mem_A);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({ack0, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rsta_no_ack: got %b want 00", {ack0, busy});
    end
    req0 = 1'b1; we0 = 1'b0; A0 = 32'h40;
    tick();
    tick();
    n_tests++;
    if (ack0 !== 1'b1 || RD0 !== 32'h55) begin
      n_fail++;
      $display("FAIL rsta_readback: got ack0=%b RD0=%h want 1 55", ack0, RD0);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_resp();
    req1 = 1'b1; we1 = 1'b0; A1 = 32'h10;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (ack1 !== 1'b1 || RD1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rstr_ack_visible: got ack1=%b RD1=%h want 1 deadbeef", ack1, RD1);
    end
    req1 = 1'b0;
    tick();
    n_tests++;
    if ({ack0, ack1, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstr_after: got %b want 000", {ack0, ack1, busy});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; we0 = 1'b0; A0 = 32'h10;
    for (int c = 1; c <= 11; c++) begin
      logic e0, eb;
      tick();
      e0 = (c % 3) == 2;
      eb = (c % 3) != 0;
      n_tests++;
      if ({ack0, busy} !== {e0, eb} || ack1 !== 1'b0 || RD1 !== 32'h0) begin
        n_fail++;
        $display("FAIL b2b_c%0d: got ack0=%b busy=%b ack1=%b RD1=%h want %b %b 0 0",
                 c, ack0, busy, ack1, RD1, e0, eb);
      end
      if (e0) begin
        n_tests++;
        if (RD0 !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL b2b_rd_c%0d: got %h want deadbeef", c, RD0);
        end
      end
    end
    idle_ports();
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end_busy: got %b want 0", busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_ports();
    test_reset();
    test_read();
    test_write();
    test_contended();
    test_wr_rd_collision();
    test_reset_in_access();
    test_reset_in_resp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
